// File: rtl/trace_logger_mc_pkg.sv
// Shared defaults, FSM encoding and helpers for the multi-channel trace logger.
package trace_logger_mc_pkg;

   localparam int TRB_WIDTH_DEF      = 64;
   localparam int TRB_DEPTH_DEF      = 64;
   localparam int TRB_CHANNELS_DEF   = 4;
   localparam int TRB_DELAY_BITS_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP
   } logger_state_t;

   // Number of exchanges still allowed after the trigger: DELAY/2^bits of the buffer.
   function automatic int unsigned post_count(input int unsigned delay,
                                              input int unsigned depth,
                                              input int unsigned delay_bits);
      return (delay * depth) >> delay_bits;
   endfunction

endpackage

// File: rtl/trace_logger_mc_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the most recently granted channel.
module rr_arbiter #(
   parameter  int CHANNELS = 4,
   localparam int IW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] req,
   input  logic                advance,
   output logic [CHANNELS-1:0] gnt,
   output logic [IW-1:0]       gnt_idx
);

   logic [IW-1:0] last;

   // Pick the first requester after the last grant, wrapping around.
   always_comb begin
      logic          found;
      int            cand;
      logic [IW-1:0] cand_idx;
      // NOTE: every output gets a default before the search so no path can infer a latch.
      gnt      = '0;
      gnt_idx  = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 1; i <= CHANNELS; i++) begin
         cand     = (int'(last) + i) % CHANNELS;
         cand_idx = IW'(cand);
         if (!found && req[cand_idx]) begin
            found         = 1'b1;
            gnt[cand_idx] = 1'b1;
            gnt_idx       = cand_idx;
         end
      end
   end

   // Remember the channel that was actually served; after reset channel 0 goes first.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses <= so every flop samples the pre-edge values.
      if (rst)          last <= IW'(CHANNELS - 1);
      else if (advance) last <= gnt_idx;
   end

endmodule

// File: rtl/trace_logger_mc.sv
// Multi-channel trace logger: per-channel holding registers, round-robin
// exchange with a circular trace buffer, trigger capture and post-trigger stop.
module trace_logger_mc
   import trace_logger_mc_pkg::*;
#(
   parameter  int TRB_WIDTH      = TRB_WIDTH_DEF,
   parameter  int TRB_DEPTH      = TRB_DEPTH_DEF,
   parameter  int TRB_CHANNELS   = TRB_CHANNELS_DEF,
   parameter  int TRB_DELAY_BITS = TRB_DELAY_BITS_DEF,
   localparam int PW             = $clog2(TRB_DEPTH),
   localparam int CW             = (TRB_CHANNELS > 1) ? $clog2(TRB_CHANNELS) : 1
) (
   input  logic                              CLK_I,
   input  logic                              RST_I,
   input  logic                              ENABLE_I,
   input  logic                              MODE_I,
   input  logic [TRB_DELAY_BITS-1:0]         DELAY_I,
   input  logic                              TRG_EVENT_I,
   input  logic [TRB_CHANNELS-1:0]           LOAD_I,
   input  logic [TRB_CHANNELS*TRB_WIDTH-1:0] DATA_I,
   output logic [TRB_CHANNELS-1:0]           STORE_O,
   output logic [TRB_WIDTH-1:0]              DATA_O,
   output logic                              RW_O,
   input  logic                              RW_TURN_I,
   output logic [PW-1:0]                     RW_PTR_O,
   output logic [TRB_WIDTH-1:0]              DMEM_O,
   input  logic [TRB_WIDTH-1:0]              DMEM_I,
   output logic [PW-1:0]                     EVENT_ADDR_O,
   output logic                              TRG_DONE_O,
   output logic                              WRAP_O,
   output logic [TRB_CHANNELS-1:0]           OVF_O
);

   logger_state_t           state, state_nxt;
   logic [TRB_CHANNELS-1:0] hold_valid;
   logic [TRB_WIDTH-1:0]    hold_data [TRB_CHANNELS];
   logic [TRB_CHANNELS-1:0] arb_gnt;
   logic [CW-1:0]           arb_idx;
   logic [TRB_CHANNELS-1:0] sel;
   logic                    advance;
   logic                    exchange;
   logic [PW-1:0]           ptr;
   logic [PW:0]             post_cnt;
   logic                    trig_seen;

   assign RW_PTR_O   = ptr;
   assign exchange   = ENABLE_I && (state == ST_REQ) && RW_TURN_I;
   // Once the post-trigger budget is spent in trace mode, no new exchange may start.
   assign TRG_DONE_O = trig_seen && (post_cnt == '0) && !MODE_I;

   rr_arbiter #(.CHANNELS(TRB_CHANNELS)) u_arb (
      .clk     (CLK_I),
      .rst     (RST_I),
      .req     (hold_valid),
      .advance (advance),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   // FSM state register.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next state, grant acceptance and the memory request strobe.
   always_comb begin
      state_nxt = state;
      advance   = 1'b0;
      RW_O      = 1'b0;
      if (!ENABLE_I) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if ((|hold_valid) && !TRG_DONE_O) begin
                  advance   = 1'b1;
                  state_nxt = ST_REQ;
               end
            end
            ST_REQ: begin
               RW_O = 1'b1;
               if (RW_TURN_I) state_nxt = ST_RESP;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Holding-register valid bits and sticky per-channel overflow flags.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         hold_valid <= '0;
         OVF_O      <= '0;
      end else if (!ENABLE_I) begin
         hold_valid <= '0;
      end else begin
         for (int c = 0; c < TRB_CHANNELS; c++) begin
            if (exchange && sel[c]) hold_valid[c] <= 1'b0;
            if (LOAD_I[c]) begin
               if (hold_valid[c]) OVF_O[c]      <= 1'b1;
               else               hold_valid[c] <= 1'b1;
            end
         end
      end
   end

   // Holding-register payload; only meaningful while the matching valid bit is set.
   always_ff @(posedge CLK_I) begin
      // NOTE: payload storage has no reset; the valid bits alone define emptiness.
      for (int c = 0; c < TRB_CHANNELS; c++) begin
         if (ENABLE_I && LOAD_I[c] && !hold_valid[c])
            hold_data[c] <= DATA_I[c*TRB_WIDTH +: TRB_WIDTH];
      end
   end

   // Exchange datapath: latch the grant, drive the write word, capture the old word.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         ptr     <= '0;
         WRAP_O  <= 1'b0;
         DATA_O  <= '0;
         DMEM_O  <= '0;
         sel     <= '0;
         STORE_O <= '0;
      end else begin
         STORE_O <= (ENABLE_I && state == ST_RESP) ? sel : '0;
         if (!ENABLE_I) begin
            ptr    <= '0;
            DMEM_O <= '0;
         end else begin
            if (advance) begin
               sel    <= arb_gnt;
               DMEM_O <= hold_data[arb_idx];
            end
            if (exchange) begin
               DATA_O <= DMEM_I;
               ptr    <= ptr + 1'b1;
               if (&ptr) WRAP_O <= 1'b1;
            end
         end
      end
   end

   // Trigger capture and post-trigger countdown, saturating at zero.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         trig_seen    <= 1'b0;
         EVENT_ADDR_O <= '0;
         post_cnt     <= '0;
      end else if (!ENABLE_I) begin
         trig_seen    <= 1'b0;
         EVENT_ADDR_O <= '0;
         post_cnt     <= '0;
      end else if (TRG_EVENT_I && !trig_seen) begin
         trig_seen    <= 1'b1;
         EVENT_ADDR_O <= ptr;
         post_cnt     <= (PW+1)'(post_count(32'(DELAY_I), TRB_DEPTH, TRB_DELAY_BITS));
      end else if (trig_seen && exchange && (post_cnt != '0)) begin
         post_cnt <= post_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_trace_logger_mc.sv
// Scoreboard bench for trace_logger_mc: stimulus pushes expected writes and
// returns; monitors pop and compare whenever the DUT exchanges or stores.
module tb_trace_logger_mc;

   localparam int W  = 64;
   localparam int D  = 64;
   localparam int N  = 4;
   localparam int DB = 3;
   localparam int PW = 6;

   logic            CLK_I = 1'b0;
   logic            RST_I = 1'b1;
   logic            ENABLE_I = 1'b0;
   logic            MODE_I = 1'b0;
   logic [DB-1:0]   DELAY_I = '0;
   logic            TRG_EVENT_I = 1'b0;
   logic [N-1:0]    LOAD_I = '0;
   logic [N*W-1:0]  DATA_I = '0;
   logic [N-1:0]    STORE_O;
   logic [W-1:0]    DATA_O;
   logic            RW_O;
   logic            RW_TURN_I = 1'b1;
   logic [PW-1:0]   RW_PTR_O;
   logic [W-1:0]    DMEM_O;
   logic [W-1:0]    DMEM_I;
   logic [PW-1:0]   EVENT_ADDR_O;
   logic            TRG_DONE_O;
   logic            WRAP_O;
   logic [N-1:0]    OVF_O;

   trace_logger_mc #(.TRB_WIDTH(W), .TRB_DEPTH(D), .TRB_CHANNELS(N), .TRB_DELAY_BITS(DB)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .ENABLE_I(ENABLE_I), .MODE_I(MODE_I), .DELAY_I(DELAY_I),
      .TRG_EVENT_I(TRG_EVENT_I), .LOAD_I(LOAD_I), .DATA_I(DATA_I), .STORE_O(STORE_O),
      .DATA_O(DATA_O), .RW_O(RW_O), .RW_TURN_I(RW_TURN_I), .RW_PTR_O(RW_PTR_O),
      .DMEM_O(DMEM_O), .DMEM_I(DMEM_I), .EVENT_ADDR_O(EVENT_ADDR_O),
      .TRG_DONE_O(TRG_DONE_O), .WRAP_O(WRAP_O), .OVF_O(OVF_O)
   );

   always #5 CLK_I = ~CLK_I;

   int cycle = 0;
   always @(posedge CLK_I) cycle <= cycle + 1;

   // Trace-buffer memory model: combinational read, write on a granted exchange.
   logic [W-1:0] mem [D];
   assign DMEM_I = mem[RW_PTR_O];
   always @(posedge CLK_I) if (RW_O && RW_TURN_I) mem[RW_PTR_O] <= DMEM_O;

   typedef struct { int ptr; logic [W-1:0] data; } wr_t;
   typedef struct { int ch; logic [W-1:0] data; int lcyc; bit lat; } st_t;
   wr_t wq[$];
   st_t sq[$];
   wr_t we;
   st_t se;

   logic [W-1:0] exp_mem [D];
   int exp_ptr = 0;
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Exchange monitor: the word and address presented to memory in a granted cycle.
   always @(negedge CLK_I) begin
      if (!RST_I && RW_O && RW_TURN_I) begin
         if (wq.size() == 0) check("unexpected_write", 64'd1, 64'd0);
         else begin
            we = wq.pop_front();
            check("wr_ptr", 64'(RW_PTR_O), 64'(we.ptr));
            check("wr_data", DMEM_O, we.data);
         end
      end
   end

   // Return monitor: which channel is told, what old word it gets, and when.
   always @(negedge CLK_I) begin
      if (STORE_O != '0) begin
         if (sq.size() == 0) check("unexpected_store", 64'(STORE_O), 64'd0);
         else begin
            se = sq.pop_front();
            check("store_onehot", 64'(STORE_O), 64'd1 << se.ch);
            check("store_data", DATA_O, se.data);
            if (se.lat) check("store_latency", 64'(cycle - se.lcyc), 64'd4);
         end
      end
   end

   task automatic do_reset();
      @(negedge CLK_I);
      RST_I = 1'b1; ENABLE_I = 1'b0; LOAD_I = '0; TRG_EVENT_I = 1'b0; RW_TURN_I = 1'b1;
      for (int i = 0; i < D; i++) begin
         mem[i] = 64'h100 + 64'(i);
         exp_mem[i] = 64'h100 + 64'(i);
      end
      exp_ptr = 0;
      wq.delete();
      sq.delete();
      repeat (2) @(negedge CLK_I);
      check("rst_ctrl", 64'({STORE_O, RW_O, RW_PTR_O, EVENT_ADDR_O, TRG_DONE_O, WRAP_O, OVF_O}), 64'd0);
      check("rst_data", DATA_O | DMEM_O, 64'd0);
      RST_I = 1'b0; ENABLE_I = 1'b1;
      @(negedge CLK_I);
   endtask

   task automatic pulse_load(input logic [N-1:0] mask, input logic [W-1:0] base, output int lcyc);
      @(negedge CLK_I);
      LOAD_I = mask;
      for (int c = 0; c < N; c++) DATA_I[c*W +: W] = base + 64'(c);
      lcyc = cycle;
      @(negedge CLK_I);
      LOAD_I = '0;
   endtask

   task automatic expect_xfer(input int ch, input logic [W-1:0] d, input int lcyc, input bit lat);
      wq.push_back('{ptr: exp_ptr, data: d});
      sq.push_back('{ch: ch, data: exp_mem[exp_ptr], lcyc: lcyc, lat: lat});
      exp_mem[exp_ptr] = d;
      exp_ptr = (exp_ptr + 1) % D;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && (wq.size() != 0 || sq.size() != 0); i++) @(negedge CLK_I);
      if (wq.size() != 0 || sq.size() != 0) begin
         check("drain_timeout", 64'(wq.size() + sq.size()), 64'd0);
         wq.delete();
         sq.delete();
      end
   endtask

   // One channel stores one word; the word lands on DATA_I[ch] as base+ch.
   task automatic xfer(input int ch, input logic [W-1:0] d, input bit lat);
      int lc;
      pulse_load(N'(1) << ch, d - 64'(ch), lc);
      expect_xfer(ch, d, lc, lat);
      wait_drain(20);
   endtask

   task automatic pulse_trigger();
      @(negedge CLK_I);
      TRG_EVENT_I = 1'b1;
      @(negedge CLK_I);
      TRG_EVENT_I = 1'b0;
   endtask

   task automatic count_rw(input int ncyc, output int seen);
      seen = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge CLK_I);
         if (RW_O) seen++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lc;
      int seen;

      // Single channel, three words, fixed latency.
      do_reset();
      for (int i = 0; i < 3; i++) xfer(0, 64'hA5, 1'b1);

      // Two simultaneous bursts from all channels: 0,1,2,3 each time, no overflow.
      do_reset();
      for (int b = 0; b < 2; b++) begin
         pulse_load(4'hF, 64'h10 * 64'(b + 1), lc);
         for (int c = 0; c < N; c++) expect_xfer(c, 64'h10 * 64'(b + 1) + 64'(c), lc, 1'b0);
         wait_drain(60);
      end
      check("burst_ovf", 64'(OVF_O), 64'd0);

      // Trace mode, DELAY=4: trigger at ptr 10, stop after 32 exchanges.
      do_reset();
      MODE_I = 1'b0; DELAY_I = 3'd4;
      for (int i = 0; i < 10; i++) xfer(i % N, 64'h300 + 64'(i), 1'b0);
      pulse_trigger();
      check("trace_event_addr", 64'(EVENT_ADDR_O), 64'd10);
      check("trace_done_early", 64'(TRG_DONE_O), 64'd0);
      for (int i = 0; i < 31; i++) xfer(i % N, 64'h400 + 64'(i), 1'b0);
      check("trace_done_at31", 64'(TRG_DONE_O), 64'd0);
      xfer(1, 64'h4FF, 1'b0);
      check("trace_done_at32", 64'(TRG_DONE_O), 64'd1);
      check("trace_ptr", 64'(RW_PTR_O), 64'd42);
      pulse_load(4'b0001, 64'h999, lc);
      count_rw(10, seen);
      check("trace_suppressed_rw", 64'(seen), 64'd0);
      check("trace_done_sticky", 64'(TRG_DONE_O), 64'd1);

      // Trace mode, DELAY=0: done the cycle after the trigger is seen.
      do_reset();
      MODE_I = 1'b0; DELAY_I = 3'd0;
      check("d0_done_before", 64'(TRG_DONE_O), 64'd0);
      pulse_trigger();
      check("d0_done_after", 64'(TRG_DONE_O), 64'd1);
      check("d0_event_addr", 64'(EVENT_ADDR_O), 64'd0);
      pulse_load(4'b0100, 64'h777, lc);
      count_rw(8, seen);
      check("d0_suppressed_rw", 64'(seen), 64'd0);

      // Stream mode: 70 exchanges wrap the buffer and never stop.
      do_reset();
      MODE_I = 1'b1; DELAY_I = 3'd0;
      pulse_trigger();
      check("stream_event_addr", 64'(EVENT_ADDR_O), 64'd0);
      for (int i = 0; i < 70; i++) begin
         xfer(i % N, 64'h1000 + 64'(i), 1'b0);
         if (i == 62) check("stream_wrap_63", 64'(WRAP_O), 64'd0);
         if (i == 63) check("stream_wrap_64", 64'(WRAP_O), 64'd1);
      end
      check("stream_done", 64'(TRG_DONE_O), 64'd0);
      check("stream_ptr", 64'(RW_PTR_O), 64'd6);

      // Memory turn withheld: second load on channel 1 overflows, first still served.
      do_reset();
      MODE_I = 1'b0; DELAY_I = 3'd0;
      RW_TURN_I = 1'b0;
      pulse_load(4'b0010, 64'h55 - 64'd1, lc);
      expect_xfer(1, 64'h55, lc, 1'b0);
      repeat (2) @(negedge CLK_I);
      pulse_load(4'b0010, 64'h66 - 64'd1, lc);
      repeat (5) @(negedge CLK_I);
      check("ovf_bit", 64'(OVF_O), 64'b0010);
      check("ovf_rw_waiting", 64'(RW_O), 64'd1);
      RW_TURN_I = 1'b1;
      wait_drain(20);
      repeat (6) @(negedge CLK_I);
      check("ovf_ptr", 64'(RW_PTR_O), 64'd1);

      // Asynchronous reset in the middle of a pending request.
      do_reset();
      RW_TURN_I = 1'b0;
      pulse_load(4'b0100, 64'h88, lc);
      repeat (2) @(negedge CLK_I);
      check("midreq_rw", 64'(RW_O), 64'd1);
      #2 RST_I = 1'b1;
      #1;
      check("async_rst_ctrl", 64'({STORE_O, RW_O, RW_PTR_O, EVENT_ADDR_O, TRG_DONE_O, WRAP_O, OVF_O}), 64'd0);
      check("async_rst_data", DATA_O | DMEM_O, 64'd0);
      @(negedge CLK_I);
      RST_I = 1'b0;
      RW_TURN_I = 1'b1;
      count_rw(8, seen);
      check("post_rst_rw", 64'(seen), 64'd0);
      check("post_rst_ptr", 64'(RW_PTR_O), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
